branch_resolver: RTL and testbench

//  Consumer side of the status register: reads the registered Z/N/V flags,

---
 rtl/branch_resolver_pkg.sv | 27 ++
 rtl/branch_resolver_cond_eval.sv | 32 +++
 rtl/branch_resolver.sv | 90 +++++++++
 tb/tb_branch_resolver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: condition codes, FSM states and busy counter width.
package branch_resolver_pkg;

    typedef enum logic [3:0] {
        CondAl = 4'd0,
        CondEq = 4'd1,
        CondNe = 4'd2,
        CondLt = 4'd3,
        CondGe = 4'd4,
        CondMi = 4'd5,
        CondPl = 4'd6,
        CondVs = 4'd7,
        CondVc = 4'd8,
        CondGt = 4'd9,
        CondLe = 4'd10
    } cond_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Wide enough for the largest supported flag latency of 7.
    localparam int unsigned BusyW = 3;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational condition-code evaluation against the Z/N/V flags.
module branch_resolver_cond_eval
    import branch_resolver_pkg::*;
(
    input  logic [3:0] br_cond,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_cond)
            CondAl:  taken = 1'b1;
            CondEq:  taken = z;
            CondNe:  taken = ~z;
            CondLt:  taken = n ^ v;
            CondGe:  taken = ~(n ^ v);
            CondMi:  taken = n;
            CondPl:  taken = ~n;
            CondVs:  taken = v;
            CondVc:  taken = ~v;
            CondGt:  taken = ~z & ~(n ^ v);
            CondLe:  taken = z | (n ^ v);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: waits out in-flight flag writes, evaluates the condition and
// issues a registered one-cycle PC redirect, with wrap-around debug counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned FLAG_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_offset,
    input  logic             flag_wr,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             flag_v,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             illegal_cond,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [BusyW-1:0] LatLoad = BusyW'(FLAG_LAT);

    logic [BusyW-1:0] busy_q;
    state_e           state_q;
    logic             flags_busy;
    logic             accept;
    logic             taken;
    logic             illegal;
    logic [31:0]      target;

    assign flags_busy = (busy_q != '0);
    assign stall      = (state_q == StWait) ? flags_busy : (br_valid & flags_busy);
    assign accept     = br_valid & ~stall;
    assign target     = br_pc + (br_offset << 2);

    branch_resolver_cond_eval u_cond_eval (
        .br_cond (br_cond),
        .z       (flag_z),
        .n       (flag_n),
        .v       (flag_v),
        .taken   (taken),
        .illegal (illegal)
    );

    // A flag write in the same cycle as an accept only delays later branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (flag_wr) begin
            busy_q <= LatLoad;
        end else if (flags_busy) begin
            busy_q <= busy_q - BusyW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
            illegal_cond <= 1'b0;
            br_count     <= '0;
            taken_count  <= '0;
        end else begin
            redirect     <= accept & taken;
            redirect_pc  <= (accept & taken) ? target : '0;
            illegal_cond <= accept & illegal;
            if (accept) begin
                br_count <= br_count + CNT_W'(1);
                if (taken) begin
                    taken_count <= taken_count + CNT_W'(1);
                end
            end
            if (accept) begin
                state_q <= StResp;
            end else if (br_valid) begin
                state_q <= StWait;
            end else begin
                state_q <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed, table-driven bench for branch_resolver (FLAG_LAT=3) plus a narrow-counter
// instance used to exercise counter wrap-around.
module tb_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        flag_wr;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal_cond;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    logic        s_valid;
    logic        s_stall;
    logic        s_redirect;
    logic [31:0] s_pc;
    logic        s_illegal;
    logic [3:0]  s_brc;
    logic [3:0]  s_tkc;

    int checks = 0;
    int errors = 0;
    int br_m   = 0;
    int tk_m   = 0;

    branch_resolver #(.FLAG_LAT(3), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (br_valid),
        .br_cond      (br_cond),
        .br_pc        (br_pc),
        .br_offset    (br_offset),
        .flag_wr      (flag_wr),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_v       (flag_v),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .illegal_cond (illegal_cond),
        .br_count     (br_count),
        .taken_count  (taken_count)
    );

    branch_resolver #(.FLAG_LAT(1), .CNT_W(4)) u_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (s_valid),
        .br_cond      (4'd0),
        .br_pc        (32'h0),
        .br_offset    (32'h1),
        .flag_wr      (1'b0),
        .flag_z       (1'b0),
        .flag_n       (1'b0),
        .flag_v       (1'b0),
        .stall        (s_stall),
        .redirect     (s_redirect),
        .redirect_pc  (s_pc),
        .illegal_cond (s_illegal),
        .br_count     (s_brc),
        .taken_count  (s_tkc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running required done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  cond;
        logic        z;
        logic        n;
        logic        v;
        logic [31:0] pc;
        logic [31:0] off;
        logic        taken;
        logic        ill;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'd1,  1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0110};
        vecs[1]  = '{4'd3,  1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0004, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{4'd9,  1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_2040};
        vecs[3]  = '{4'd10, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0044};
        vecs[4]  = '{4'd13, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0004, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{4'd0,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0010};
        vecs[6]  = '{4'd0,  1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFF0};
        vecs[7]  = '{4'd2,  1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0004, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{4'd4,  1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0004, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{4'd5,  1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_1000};
        vecs[10] = '{4'd6,  1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0004, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{4'd7,  1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0010};
        vecs[12] = '{4'd8,  1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0004, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{4'd11, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0000_0004, 1'b0, 1'b1, 32'h0};
        vecs[14] = '{4'd15, 1'b0, 1'b0, 1'b0, 32'h0000_0900, 32'h0000_0004, 1'b0, 1'b1, 32'h0};
        vecs[15] = '{4'd10, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_000C};
        vecs[16] = '{4'd9,  1'b1, 1'b0, 1'b0, 32'h0000_0A00, 32'h0000_0004, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0; br_valid = 1'b0; br_cond = 4'd0; br_pc = 32'h0; br_offset = 32'h0;
        flag_wr = 1'b0; flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0; s_valid = 1'b0;

        // Reset values
        #2;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_redirect", {31'b0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_illegal", {31'b0, illegal_cond}, 32'd0);
        check("rst_br_count", {16'b0, br_count}, 32'd0);
        check("rst_taken_count", {16'b0, taken_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table: one branch per cycle, no flag writes in flight
        for (int i = 0; i < 17; i++) begin
            br_valid = 1'b1; br_cond = vecs[i].cond; br_pc = vecs[i].pc; br_offset = vecs[i].off;
            flag_z = vecs[i].z; flag_n = vecs[i].n; flag_v = vecs[i].v;
            #1;
            check($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
            step();
            br_valid = 1'b0;
            br_m = (br_m + 1) & 16'hFFFF;
            if (vecs[i].taken) tk_m = (tk_m + 1) & 16'hFFFF;
            check($sformatf("v%0d_redirect", i), {31'b0, redirect}, {31'b0, vecs[i].taken});
            if (vecs[i].taken) check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].tgt);
            check($sformatf("v%0d_illegal", i), {31'b0, illegal_cond}, {31'b0, vecs[i].ill});
            check($sformatf("v%0d_br_count", i), {16'b0, br_count}, br_m);
            check($sformatf("v%0d_taken_count", i), {16'b0, taken_count}, tk_m);
        end
        step();
        check("pulse_redirect_low", {31'b0, redirect}, 32'd0);
        check("pulse_illegal_low", {31'b0, illegal_cond}, 32'd0);

        // Flag write at t0, branch at t1 waits until the flags settle
        br_cond = 4'd1; flag_z = 1'b0; br_pc = 32'h0000_3000; br_offset = 32'h0000_0005;
        flag_wr = 1'b1;
        step();
        flag_wr = 1'b0; br_valid = 1'b1;
        #1 check("lat_stall_t1", {31'b0, stall}, 32'd1);
        step();
        check("lat_stall_t2", {31'b0, stall}, 32'd1);
        check("lat_no_redirect_t2", {31'b0, redirect}, 32'd0);
        step();
        flag_z = 1'b1;
        #1 check("lat_stall_t3", {31'b0, stall}, 32'd1);
        step();
        check("lat_stall_t4", {31'b0, stall}, 32'd0);
        step();
        br_valid = 1'b0;
        br_m++; tk_m++;
        check("lat_redirect_t5", {31'b0, redirect}, 32'd1);
        check("lat_redirect_pc_t5", redirect_pc, 32'h0000_3014);
        check("lat_br_count", {16'b0, br_count}, br_m);
        step();

        // flag_wr coincident with accept: current flags used, next branch waits
        br_valid = 1'b1; br_cond = 4'd1; flag_z = 1'b1; br_pc = 32'h0000_0020; br_offset = 32'h1;
        flag_wr = 1'b1;
        #1 check("sim_stall", {31'b0, stall}, 32'd0);
        step();
        flag_wr = 1'b0; flag_z = 1'b0;
        br_m++; tk_m++;
        check("sim_redirect", {31'b0, redirect}, 32'd1);
        check("sim_redirect_pc", redirect_pc, 32'h0000_0024);
        check("sim_next_stall", {31'b0, stall}, 32'd1);
        step();
        step();
        check("sim_next_stall_t3", {31'b0, stall}, 32'd1);
        step();
        check("sim_next_free", {31'b0, stall}, 32'd0);
        step();
        br_valid = 1'b0;
        br_m++;
        check("sim_next_not_taken", {31'b0, redirect}, 32'd0);
        check("sim_br_count", {16'b0, br_count}, br_m);
        check("sim_taken_count", {16'b0, taken_count}, tk_m);

        // Narrow counters wrap after 16 taken branches
        s_valid = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("wrap_taken_f", {28'b0, s_tkc}, 32'hF);
        check("wrap_br_f", {28'b0, s_brc}, 32'hF);
        check("wrap_redirect_pc", s_pc, 32'h4);
        step();
        s_valid = 1'b0;
        check("wrap_taken_0", {28'b0, s_tkc}, 32'h0);
        check("wrap_br_0", {28'b0, s_brc}, 32'h0);

        // Async reset asserted mid-wait
        step();
        flag_wr = 1'b1;
        step();
        flag_wr = 1'b0; br_valid = 1'b1; br_cond = 4'd0;
        step();
        check("wait_stall", {31'b0, stall}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_stall", {31'b0, stall}, 32'd0);
        check("arst_redirect", {31'b0, redirect}, 32'd0);
        check("arst_br_count", {16'b0, br_count}, 32'd0);
        check("arst_taken_count", {16'b0, taken_count}, 32'd0);
        br_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        br_m = 0; tk_m = 0;
        step();
        br_valid = 1'b1; br_cond = 4'd0; br_pc = 32'h0000_0020; br_offset = 32'h0;
        #1 check("post_rst_stall", {31'b0, stall}, 32'd0);
        step();
        br_valid = 1'b0;
        check("post_rst_redirect", {31'b0, redirect}, 32'd1);
        check("post_rst_redirect_pc", redirect_pc, 32'h0000_0020);
        check("post_rst_br_count", {16'b0, br_count}, 32'd1);

        // Async reset drops a pending redirect immediately
        #2 rst_n = 1'b0;
        #1;
        check("drop_redirect", {31'b0, redirect}, 32'd0);
        check("drop_redirect_pc", redirect_pc, 32'd0);
        check("drop_br_count", {16'b0, br_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
